board_state_writer: RTL and testbench

//  Write-side owner of the 10-slot game board (status[39:0]) that chooseadder-style selectors read.

---
 rtl/game_pkg.sv | 53 +++++
 rtl/row_cleared.sv | 24 ++
 rtl/board_state_writer.sv | 178 +++++++++++++++++
 tb/tb_board_state_writer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | game_pkg                                                                   |
// | Shared board geometry, FSM state type, winner codes and board helpers.     |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
package game_pkg;

    localparam int SLOT_W   = 4;
    localparam int SLOTS    = 10;
    localparam int ROW_OFS  = 20;
    localparam int MAX_COLS = 5;
    localparam int ROW_W    = MAX_COLS * SLOT_W;
    localparam int BOARD_W  = SLOTS * SLOT_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    function automatic logic [2:0] clamp_num(input logic [2:0] n);
        if (n == 3'd0)
            return 3'd1;
        else if (n > 3'd5)
            return 3'd5;
        else
            return n;
    endfunction

    function automatic logic [BOARD_W-1:0] init_board(input logic [SLOT_W-1:0] val,
                                                      input logic [2:0]        n);
        logic [BOARD_W-1:0] b;
        b = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if ((k % MAX_COLS) < int'(n))
                b[k*SLOT_W +: SLOT_W] = val;
        end
        return b;
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] d);
        return (d == 3'd7) ? 3'd7 : d + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_cleared.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | row_cleared                                                                |
// | Flags a board row whose active slots (col < num_q) are all zero.           |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module row_cleared
    import game_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    input  logic [2:0]       num_q,
    output logic             cleared
);

    logic [MAX_COLS-1:0] col_ok;

    for (genvar c = 0; c < MAX_COLS; c++) begin : g_col
        assign col_ok[c] = (3'(c) >= num_q) || (row[c*SLOT_W +: SLOT_W] == '0);
    end

    assign cleared = &col_ok;

endmodule
`default_nettype wire

// File: rtl/board_state_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_state_writer                                                         |
// | Sole writer of the 10-slot game board: validates, applies and scores moves.|
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module board_state_writer
    import game_pkg::*;
#(
    parameter int INIT_VAL    = 1,
    parameter int NUM_DEFAULT = 5,
    parameter int DRAW_LIMIT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic [2:0]         num,
    input  logic               move_valid,
    output logic               move_ready,
    // 6 bits so that row-1 offsets up to 36 are addressable
    input  logic [5:0]         move_index,
    input  logic [3:0]         move_value,
    input  logic               move_draw,
    output logic               move_err,
    output logic [BOARD_W-1:0] status,
    output logic               player,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [2:0]         p0_draws,
    output logic [2:0]         p1_draws
);

    localparam logic [SLOT_W-1:0] INIT_V    = SLOT_W'(INIT_VAL);
    localparam logic [2:0]        NUM_DEF   = 3'(NUM_DEFAULT);
    localparam logic [2:0]        DRAW_LIM  = 3'(DRAW_LIMIT);

    state_t             state_q, state_d;
    logic [BOARD_W-1:0] status_q, status_d;
    logic [2:0]         num_q, num_d;
    logic               player_q, player_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;
    logic [2:0]         p0_draws_q, p0_draws_d;
    logic [2:0]         p1_draws_q, p1_draws_d;
    logic               move_err_q, move_err_d;
    logic [5:0]         idx_q, idx_d;
    logic [3:0]         val_q, val_d;
    logic               draw_q, draw_d;

    logic               row0_clr, row1_clr;
    logic               row_sel;
    logic [5:0]         col_ofs;
    logic               move_bad;
    logic [2:0]         ng_num;

    row_cleared u_row0 (.row(status_q[ROW_W-1:0]),       .num_q(num_q), .cleared(row0_clr));
    row_cleared u_row1 (.row(status_q[BOARD_W-1:ROW_W]), .num_q(num_q), .cleared(row1_clr));

    // Offset within the row; alignment survives the subtraction since ROW_OFS is a multiple of 4
    always_comb begin
        row_sel  = (move_index >= 6'(ROW_OFS));
        col_ofs  = move_index - (row_sel ? 6'(ROW_OFS) : 6'd0);
        move_bad = (col_ofs[1:0] != 2'd0)
                || (move_index > 6'd36)
                || ({2'b00, col_ofs[5:2]} >= {3'b000, num_q})
                || (row_sel != player_q)
                || (move_value > 4'd9);
        ng_num   = clamp_num(num);
    end

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        num_d       = num_q;
        player_d    = player_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        p0_draws_d  = p0_draws_q;
        p1_draws_d  = p1_draws_q;
        move_err_d  = 1'b0;
        idx_d       = idx_q;
        val_d       = val_q;
        draw_d      = draw_q;

        if (new_game) begin
            num_d       = ng_num;
            status_d    = init_board(INIT_V, ng_num);
            player_d    = 1'b0;
            game_over_d = 1'b0;
            winner_d    = WIN_NONE;
            p0_draws_d  = 3'd0;
            p1_draws_d  = 3'd0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (move_valid) begin
                        if (move_bad) begin
                            move_err_d = 1'b1;
                        end else begin
                            idx_d   = move_index;
                            val_d   = move_value;
                            draw_d  = move_draw;
                            state_d = ST_APPLY;
                        end
                    end
                end
                ST_APPLY: begin
                    status_d[idx_q +: SLOT_W] = val_q;
                    if (draw_q) begin
                        if (player_q)
                            p1_draws_d = sat_inc(p1_draws_q);
                        else
                            p0_draws_d = sat_inc(p0_draws_q);
                    end
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (player_q ? row1_clr : row0_clr) begin
                        winner_d    = player_q ? WIN_P1 : WIN_P0;
                        game_over_d = 1'b1;
                        state_d     = ST_OVER;
                    end else if ((player_q ? p1_draws_q : p0_draws_q) >= DRAW_LIM) begin
                        winner_d    = WIN_TIE;
                        game_over_d = 1'b1;
                        state_d     = ST_OVER;
                    end else begin
                        player_d = ~player_q;
                        state_d  = ST_IDLE;
                    end
                end
                ST_OVER: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            status_q    <= init_board(INIT_V, NUM_DEF);
            num_q       <= NUM_DEF;
            player_q    <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
            p0_draws_q  <= 3'd0;
            p1_draws_q  <= 3'd0;
            move_err_q  <= 1'b0;
            idx_q       <= 6'd0;
            val_q       <= 4'd0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            num_q       <= num_d;
            player_q    <= player_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            p0_draws_q  <= p0_draws_d;
            p1_draws_q  <= p1_draws_d;
            move_err_q  <= move_err_d;
            idx_q       <= idx_d;
            val_q       <= val_d;
            draw_q      <= draw_d;
        end
    end

    assign move_ready = (state_q == ST_IDLE);
    assign move_err   = move_err_q;
    assign status     = status_q;
    assign player     = player_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign p0_draws   = p0_draws_q;
    assign p1_draws   = p1_draws_q;

endmodule
`default_nettype wire

// File: tb/tb_board_state_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_board_state_writer                                                      |
// | Directed scoreboard bench: stimulus queues expected responses, a monitor   |
// | pops them on move_err pulses and on move completion.                       |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_board_state_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_game = 1'b0;
    logic [2:0]  num = 3'd0;
    logic        move_valid = 1'b0;
    logic        move_ready;
    logic [5:0]  move_index = 6'd0;
    logic [3:0]  move_value = 4'd0;
    logic        move_draw = 1'b0;
    logic        move_err;
    logic [39:0] status;
    logic        player;
    logic        game_over;
    logic [1:0]  winner;
    logic [2:0]  p0_draws;
    logic [2:0]  p1_draws;

    board_state_writer #(.INIT_VAL(1), .NUM_DEFAULT(5), .DRAW_LIMIT(3)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .num(num),
        .move_valid(move_valid), .move_ready(move_ready), .move_index(move_index),
        .move_value(move_value), .move_draw(move_draw), .move_err(move_err),
        .status(status), .player(player), .game_over(game_over), .winner(winner),
        .p0_draws(p0_draws), .p1_draws(p1_draws)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [39:0] status;
        logic        player;
        logic [1:0]  winner;
        logic        go;
        logic [2:0]  p0d;
        logic [2:0]  p1d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_done(input logic [39:0] st, input logic pl, input logic [1:0] w,
                             input logic go, input logic [2:0] d0, input logic [2:0] d1);
        exp_t e;
        e.is_err = 1'b0; e.status = st; e.player = pl; e.winner = w;
        e.go = go; e.p0d = d0; e.p1d = d1;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [39:0] st, input logic pl);
        exp_t e;
        e.is_err = 1'b1; e.status = st; e.player = pl; e.winner = 2'b00;
        e.go = 1'b0; e.p0d = 3'd0; e.p1d = 3'd0;
        sb.push_back(e);
    endtask

    task automatic offer(input logic [5:0] i, input logic [3:0] v, input logic d);
        move_valid = 1'b1; move_index = i; move_value = v; move_draw = d;
        step();
        move_valid = 1'b0;
    endtask

    task automatic start_game(input logic [2:0] n);
        new_game = 1'b1; num = n;
        step();
        new_game = 1'b0;
        @(negedge clk);
    endtask

    // Full accepted move: expectation queued, then three cycles until back in IDLE/OVER
    task automatic do_move(input logic [5:0] i, input logic [3:0] v, input logic d,
                           input logic [39:0] st, input logic pl, input logic [1:0] w,
                           input logic go, input logic [2:0] d0, input logic [2:0] d1);
        push_done(st, pl, w, go, d0, d1);
        offer(i, v, d);
        step();
        step();
        @(negedge clk);
    endtask

    task automatic do_err(input string nm, input logic [5:0] i, input logic [3:0] v,
                          input logic [39:0] st, input logic pl);
        push_err(st, pl);
        offer(i, v, 1'b0);
        @(negedge clk);
        chk({nm, "_ready_held"}, 64'(move_ready), 64'd1);
        step();
        @(negedge clk);
        chk({nm, "_err_one_cycle"}, 64'(move_err), 64'd0);
    endtask

    // Monitor: consumes expectations on move_err pulses and on move completion
    initial begin
        exp_t e;
        bit   pending;
        int   pcnt;
        logic prev_ready;
        logic prev_ng;
        pending = 0; pcnt = 0; prev_ready = 1'b0; prev_ng = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
                prev_ng = 1'b0;
                prev_ready = move_ready;
            end else begin
                if (move_err) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_err: move_err=1 with no queued response at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("err_kind", 64'(e.is_err), 64'd1);
                        chk("err_status", 64'(status), 64'(e.status));
                        chk("err_player", 64'(player), 64'(e.player));
                    end
                end
                if (prev_ng) begin
                    pending = 0;
                end else if (pending) begin
                    pcnt++;
                    if (move_ready || game_over) begin
                        pending = 0;
                        if (sb.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected_done: move completed with no queued response at %0t", $time);
                        end else begin
                            e = sb.pop_front();
                            chk("done_kind", 64'(e.is_err), 64'd0);
                            chk("done_latency", 64'(pcnt), 64'd2);
                            chk("done_status", 64'(status), 64'(e.status));
                            chk("done_player", 64'(player), 64'(e.player));
                            chk("done_winner", 64'(winner), 64'(e.winner));
                            chk("done_game_over", 64'(game_over), 64'(e.go));
                            chk("done_p0_draws", 64'(p0_draws), 64'(e.p0d));
                            chk("done_p1_draws", 64'(p1_draws), 64'(e.p1d));
                        end
                    end else if (pcnt > 6) begin
                        pending = 0;
                        n_cmp++; n_bad++;
                        $display("FAIL move_timeout: no completion within 6 cycles at %0t", $time);
                    end
                end else if (prev_ready && !move_ready && !game_over) begin
                    pending = 1;
                    pcnt = 0;
                end
                prev_ready = move_ready;
                prev_ng = new_game;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_status", 64'(status), 64'h11111_11111);
        chk("rst_player", 64'(player), 64'd0);
        chk("rst_game_over", 64'(game_over), 64'd0);
        chk("rst_winner", 64'(winner), 64'd0);
        chk("rst_draws", 64'({p0_draws, p1_draws}), 64'd0);
        chk("rst_err", 64'(move_err), 64'd0);
        chk("rst_ready", 64'(move_ready), 64'd1);

        // New game with three active columns
        start_game(3'd3);
        chk("ng3_status", 64'(status), 64'h00111_00111);
        chk("ng3_player", 64'(player), 64'd0);
        chk("ng3_ready", 64'(move_ready), 64'd1);

        // Rejected moves leave everything unchanged
        do_err("bad_row", 6'd24, 4'd1, 40'h00111_00111, 1'b0);
        do_err("bad_align", 6'd6, 4'd1, 40'h00111_00111, 1'b0);
        do_err("bad_col", 6'd12, 4'd1, 40'h00111_00111, 1'b0);
        do_err("bad_val", 6'd0, 4'd10, 40'h00111_00111, 1'b0);
        do_err("bad_range", 6'd40, 4'd1, 40'h00111_00111, 1'b0);

        // First move with cycle-by-cycle latency checks
        push_done(40'h00111_00171, 1'b1, 2'b00, 1'b0, 3'd0, 3'd0);
        offer(6'd4, 4'd7, 1'b0);
        @(negedge clk);
        chk("lat_ready_low", 64'(move_ready), 64'd0);
        chk("lat_status_old", 64'(status), 64'h00111_00111);
        step();
        @(negedge clk);
        chk("lat_status_new", 64'(status), 64'h00111_00171);
        chk("lat_player_old", 64'(player), 64'd0);
        step();
        @(negedge clk);
        chk("lat_player_new", 64'(player), 64'd1);
        chk("lat_ready_back", 64'(move_ready), 64'd1);
        step();

        // Player 1 accumulates three draw moves -> tie
        do_move(6'd20, 4'd5, 1'b1, 40'h00115_00171, 1'b0, 2'b00, 1'b0, 3'd0, 3'd1);
        do_move(6'd0,  4'd2, 1'b0, 40'h00115_00172, 1'b1, 2'b00, 1'b0, 3'd0, 3'd1);
        do_move(6'd24, 4'd3, 1'b1, 40'h00135_00172, 1'b0, 2'b00, 1'b0, 3'd0, 3'd2);
        do_move(6'd8,  4'd4, 1'b0, 40'h00135_00472, 1'b1, 2'b00, 1'b0, 3'd0, 3'd2);
        do_move(6'd28, 4'd6, 1'b1, 40'h00635_00472, 1'b1, 2'b11, 1'b1, 3'd0, 3'd3);

        // Moves are ignored once the game is over
        step();
        offer(6'd20, 4'd0, 1'b0);
        step();
        @(negedge clk);
        chk("over_no_err", 64'(move_err), 64'd0);
        chk("over_ready", 64'(move_ready), 64'd0);
        chk("over_status", 64'(status), 64'h00635_00472);
        chk("over_winner", 64'(winner), 64'd3);

        // num clamping on new_game
        start_game(3'd0);
        chk("clamp0_status", 64'(status), 64'h00001_00001);
        chk("clamp0_over_cleared", 64'({game_over, winner, p1_draws}), 64'd0);
        start_game(3'd7);
        chk("clamp7_status", 64'(status), 64'h11111_11111);

        // Single column: only col 0 is legal; clearing it wins for player 0
        start_game(3'd1);
        chk("ng1_status", 64'(status), 64'h00001_00001);
        do_err("bad_col_n1", 6'd4, 4'd0, 40'h00001_00001, 1'b0);
        step();
        do_move(6'd0, 4'd0, 1'b0, 40'h00001_00000, 1'b0, 2'b01, 1'b1, 3'd0, 3'd0);
        step();
        offer(6'd0, 4'd3, 1'b0);
        @(negedge clk);
        chk("win_hold_err", 64'(move_err), 64'd0);
        chk("win_hold_status", 64'(status), 64'h00001_00000);

        // new_game during APPLY discards the move
        start_game(3'd5);
        step();
        offer(6'd0, 4'd9, 1'b0);
        new_game = 1'b1; num = 3'd2;
        step();
        new_game = 1'b0;
        @(negedge clk);
        chk("ngapply_status", 64'(status), 64'h00011_00011);
        chk("ngapply_player", 64'(player), 64'd0);
        chk("ngapply_ready", 64'(move_ready), 64'd1);
        step();
        @(negedge clk);
        chk("ngapply_no_late_write", 64'(status), 64'h00011_00011);

        // Asynchronous reset while in CHECK
        step();
        offer(6'd0, 4'd0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        chk("rstmid_status", 64'(status), 64'h11111_11111);
        chk("rstmid_player", 64'(player), 64'd0);
        chk("rstmid_ready", 64'(move_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
